// File: rtl/analogue_capture_pkg.sv
// Shared definitions for the triggered capture buffer that sits behind the
// analogue decimator: capture state encoding, trigger slope codes and the
// state-to-status-flag decode used by the capture FSM.
package analogue_capture_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRE_FILL = 3'd1,
        ARMED    = 3'd2,
        POST     = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

    // Status flags for a given state, packed as {busy, triggered, done}.
    function automatic logic [2:0] state_flags(state_t s);
        logic [2:0] f;
        f = 3'b000;
        case (s)
            PRE_FILL, ARMED: f = 3'b100;
            POST:            f = 3'b110;
            DONE:            f = 3'b011;
            default:         f = 3'b000;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/analogue_capture_sample.sv
// Sample store for the capture buffer: simple dual-port RAM, DEPTH words of
// DATA_WIDTH bits, synchronous write and registered read, written so that it
// maps onto a block RAM.
//
// Ports:
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe; rd_data only changes on cycles with rd_en=1
//   rd_addr  read address
//   rd_data  registered read data (one cycle after rd_en)
module sample_ram
    import analogue_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        // Read stage p0 -> p1: registered RAM output
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/analogue_capture.sv
// Triggered capture buffer for decimated analogue samples. Samples are
// written into a ring buffer; after a pre-trigger fill, a level/slope
// crossing (or a forced trigger) freezes a window of exactly DEPTH samples,
// pre_count of them before the trigger sample. The frozen window is read
// back by logical index, 0 being the oldest sample.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   x, x_valid   decimated sample and its strobe
//   arm          start a capture (IDLE/DONE only)
//   abort        return to IDLE from any state (wins over arm)
//   force_trig   trigger on the next valid sample while ARMED
//   trig_level   signed trigger threshold
//   trig_slope   0 rising, 1 falling
//   pre_count    pre-trigger sample count, latched on arm
//   busy         PRE_FILL/ARMED/POST
//   triggered    POST/DONE
//   done         DONE
//   trig_addr    physical RAM address of the trigger sample
//   rd_en        read request, honoured in DONE only
//   rd_addr      logical read index within the window
//   rd_data      read data, valid when rd_valid
//   rd_valid     one cycle after an accepted rd_en
module analogue_capture
    import analogue_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic                         x_valid,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         force_trig,
    input  logic signed [DATA_WIDTH-1:0] trig_level,
    input  logic                         trig_slope,
    input  logic        [ADDR_WIDTH-1:0] pre_count,
    output logic                         busy,
    output logic                         triggered,
    output logic                         done,
    output logic        [ADDR_WIDTH-1:0] trig_addr,
    input  logic                         rd_en,
    input  logic        [ADDR_WIDTH-1:0] rd_addr,
    output logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         rd_valid
);

    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

    state_t                         state;
    logic                  [2:0]    flags;
    logic         [ADDR_WIDTH-1:0]  wr_ptr;
    logic         [ADDR_WIDTH-1:0]  cnt;
    logic         [ADDR_WIDTH-1:0]  pre_lat;
    logic         [ADDR_WIDTH-1:0]  post_cnt;
    logic         [ADDR_WIDTH-1:0]  trig_addr_r;
    logic signed  [DATA_WIDTH-1:0]  prev;
    logic                           prev_valid;
    logic                           force_lat;
    logic                           rd_vld_p1;
    logic                           rd_seen;
    logic         [DATA_WIDTH-1:0]  ram_q_p1;

    logic                           capturing;
    logic                           wr_en;
    logic                           arm_ok;
    logic                           rise_hit;
    logic                           fall_hit;
    logic                           level_hit;
    logic                           trig_hit;
    logic                           rd_accept;
    logic         [ADDR_WIDTH-1:0]  cnt_inc;
    logic         [ADDR_WIDTH-1:0]  post_init;
    logic         [ADDR_WIDTH-1:0]  rd_phys;

    assign capturing = (state == PRE_FILL) || (state == ARMED) || (state == POST);
    assign wr_en     = capturing && x_valid && !abort;
    assign arm_ok    = arm && !abort && ((state == IDLE) || (state == DONE));
    assign cnt_inc   = cnt + ONE;
    // DEPTH-1-pre_count samples after the trigger complete the window.
    assign post_init = '1 - pre_lat;

    assign rise_hit = prev_valid && (prev < trig_level) && (x >= trig_level);
    assign fall_hit = prev_valid && (prev > trig_level) && (x <= trig_level);

    always_comb begin
        level_hit = 1'b0;
        case (trig_slope)
            SLOPE_RISING:  level_hit = rise_hit;
            SLOPE_FALLING: level_hit = fall_hit;
            default:       level_hit = 1'b0;
        endcase
    end

    assign trig_hit  = (state == ARMED) && wr_en && (level_hit || force_lat || force_trig);
    assign rd_accept = rd_en && (state == DONE);
    // Logical index 0 is the oldest sample: pre_count entries before the trigger.
    assign rd_phys   = trig_addr_r - pre_lat + rd_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flags       <= 3'b000;
            wr_ptr      <= '0;
            cnt         <= '0;
            pre_lat     <= '0;
            post_cnt    <= '0;
            trig_addr_r <= '0;
            prev        <= '0;
            prev_valid  <= 1'b0;
            force_lat   <= 1'b0;
            rd_vld_p1   <= 1'b0;
            rd_seen     <= 1'b0;
        end else begin
            // Read stage p0 -> p1: valid travels with the registered RAM output
            rd_vld_p1 <= rd_accept;
            rd_seen   <= rd_seen | rd_accept;

            if (wr_en) begin
                prev       <= x;
                prev_valid <= 1'b1;
                wr_ptr     <= wr_ptr + ONE;
            end

            if (abort) begin
                state     <= IDLE;
                flags     <= state_flags(IDLE);
                force_lat <= 1'b0;
            end else if (arm_ok) begin
                pre_lat    <= pre_count;
                wr_ptr     <= '0;
                cnt        <= '0;
                prev_valid <= 1'b0;
                force_lat  <= 1'b0;
                if (pre_count == '0) begin
                    state <= ARMED;
                    flags <= state_flags(ARMED);
                end else begin
                    state <= PRE_FILL;
                    flags <= state_flags(PRE_FILL);
                end
            end else begin
                case (state)
                    PRE_FILL: begin
                        if (wr_en) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == pre_lat) begin
                                state <= ARMED;
                                flags <= state_flags(ARMED);
                            end
                        end
                    end
                    ARMED: begin
                        if (force_trig) begin
                            force_lat <= 1'b1;
                        end
                        if (trig_hit) begin
                            trig_addr_r <= wr_ptr;
                            post_cnt    <= post_init;
                            force_lat   <= 1'b0;
                            if (post_init == '0) begin
                                state <= DONE;
                                flags <= state_flags(DONE);
                            end else begin
                                state <= POST;
                                flags <= state_flags(POST);
                            end
                        end
                    end
                    POST: begin
                        if (wr_en) begin
                            post_cnt <= post_cnt - ONE;
                            if (post_cnt == ONE) begin
                                state <= DONE;
                                flags <= state_flags(DONE);
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    sample_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (x),
        .rd_en   (rd_accept),
        .rd_addr (rd_phys),
        .rd_data (ram_q_p1)
    );

    // The RAM output register has no reset; mask it until the first read.
    assign rd_data   = rd_seen ? ram_q_p1 : '0;
    assign rd_valid  = rd_vld_p1;
    assign busy      = flags[2];
    assign triggered = flags[1];
    assign done      = flags[0];
    assign trig_addr = trig_addr_r;

endmodule
